// File: rtl/eris_bus_pkg.sv
// Shared timing constants, page-select opcode and link state for the serial ROM bus.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package eris_bus_pkg;

  localparam int WORD_BITS = 56;            // bit times per word cycle
  localparam int SYNC_T    = WORD_BITS - 1; // bit time where sync is low
  localparam int ADR_T0    = 20;            // first bit time of the ia address field
  localparam int ADR_BITS  = 8;
  localparam int IS_T0     = 45;            // first bit time of the is instruction field
  localparam int IS_BITS   = 10;
  localparam int MARK_T    = 11;            // ROM presence marker bit time on is
  localparam int BT_W      = 6;

  // Instruction low bits that make the ROM switch to page inst[8:7].
  localparam logic [6:0] PAGE_SEL_OP = 7'b0010000;

  typedef logic [BT_W-1:0] bit_time_t;

  // IDLE: no frames. STALL doubles as the undecided state before the
  // address decision at ADR_T0-1, since both keep ia low.
  typedef enum logic [1:0] {
    LINK_IDLE,
    LINK_SEND,
    LINK_STALL
  } link_state_t;

  function automatic bit_time_t bt(input int t);
    return bit_time_t'(t);
  endfunction

endpackage

// File: rtl/ct_rom_link_if.sv
// Bus bundle between the ROM link and its users: address handshake, serial lines, results.
// Latency: n/a (wires only).
// Backpressure: adr_valid/adr_ready handshake, one address taken per word at most.
// Ports: run, adr_i/adr_valid/adr_ready (address in), sync/ia/is (serial ROM lines),
//        inst_o/inst_valid (instruction out), cur_page, link_err (status).
interface ct_rom_link_if;
  logic       run;
  logic [7:0] adr_i;
  logic       adr_valid;
  logic       adr_ready;
  logic       sync;
  logic       ia;
  logic       is;
  logic [9:0] inst_o;
  logic       inst_valid;
  logic [1:0] cur_page;
  logic       link_err;

  modport master (
    input  run, adr_i, adr_valid, is,
    output adr_ready, sync, ia, inst_o, inst_valid, cur_page, link_err
  );

  modport slave (
    output run, adr_i, adr_valid, is,
    input  adr_ready, sync, ia, inst_o, inst_valid, cur_page, link_err
  );
endinterface

// File: rtl/eris_bit_timer.sv
// Word-cycle bit counter (0..55) with sync strobe and decoded bit-time enables.
// Latency: enables are combinational decodes of the registered counter.
// Backpressure: none; the counter parks at 55 while inactive and leaves on run.
// Ports: clk/rst_n; run (sampled at 55), active (link not idle);
//        sync, at_end, at_adr_dec, in_adr, at_mark, in_is, at_is_last.
module eris_bit_timer
  import eris_bus_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic active,
  output logic sync,
  output logic at_end,
  output logic at_adr_dec,
  output logic in_adr,
  output logic at_mark,
  output logic in_is,
  output logic at_is_last
);

  bit_time_t cnt;

  // Wraps 55 -> 0 only while run is high; otherwise parks at 55.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= bt(SYNC_T);
    end else if (cnt == bt(SYNC_T)) begin
      cnt <= run ? '0 : bt(SYNC_T);
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_end     = (cnt == bt(SYNC_T));
  assign sync       = !(at_end && active);
  assign at_adr_dec = active && (cnt == bt(ADR_T0 - 1));
  assign in_adr     = active && (cnt >= bt(ADR_T0)) && (cnt <= bt(ADR_T0 + ADR_BITS - 1));
  assign at_mark    = active && (cnt == bt(MARK_T));
  assign in_is      = active && (cnt >= bt(IS_T0)) && (cnt <= bt(IS_T0 + IS_BITS - 1));
  assign at_is_last = active && (cnt == bt(IS_T0 + IS_BITS - 1));

endmodule

// File: rtl/ct_rom_link.sv
// Initiator side of the serial ROM bus: frames words, sends addresses on ia, collects instructions from is.
// Latency: address taken at bit time 19, instruction valid at bit time 55 of the same word (36 cycles).
// Backpressure: adr_ready pulses only at bit time 19 with adr_valid; no valid address -> stall word.
// Ports: cph1 (bit clock), pon_n (async active-low reset), bus (ct_rom_link_if.master).
// Option: ERIS_MARKER_CHECK_EN enables the presence-marker check and the sticky link_err flag.
module ct_rom_link
  import eris_bus_pkg::*;
(
  input  logic                cph1,
  input  logic                pon_n,
  ct_rom_link_if.master       bus
);

  link_state_t state;
  logic [7:0]  shift;
  logic [8:0]  rx;
  logic [9:0]  rx_next;
  logic [9:0]  inst_q;
  logic        inst_vld_q;
  logic [1:0]  page_q;
  logic        word_ok;

  logic sync, at_end, at_adr_dec, in_adr, at_mark, in_is, at_is_last;

  eris_bit_timer u_timer (
    .clk        (cph1),
    .rst_n      (pon_n),
    .run        (bus.run),
    .active     (state != LINK_IDLE),
    .sync       (sync),
    .at_end     (at_end),
    .at_adr_dec (at_adr_dec),
    .in_adr     (in_adr),
    .at_mark    (at_mark),
    .in_is      (in_is),
    .at_is_last (at_is_last)
  );

  // The last instruction bit is taken straight from the line so the whole
  // word is available at bit time 54 and inst_valid can sit on bit time 55.
  assign rx_next = {bus.is, rx};

  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      state      <= LINK_IDLE;
      shift      <= '0;
      rx         <= '0;
      inst_q     <= '0;
      inst_vld_q <= 1'b0;
      page_q     <= '0;
    end else begin
      inst_vld_q <= 1'b0;
      if (in_is) begin
        rx <= rx_next[9:1];
      end
      if (in_adr) begin
        shift <= {1'b0, shift[7:1]};
      end
      if (at_adr_dec) begin
        if (bus.adr_valid) begin
          shift <= bus.adr_i;
          state <= LINK_SEND;
        end else begin
          state <= LINK_STALL;
        end
      end
      if (at_is_last && (state == LINK_SEND) && word_ok) begin
        inst_q     <= rx_next;
        inst_vld_q <= 1'b1;
        // Mirror the ROM page switch it performs on this same instruction.
        if (rx_next[6:0] == PAGE_SEL_OP) begin
          page_q <= rx_next[8:7];
        end
      end
      // New words start undecided; a run drop only takes effect here, so a
      // word already under way always completes.
      if (at_end) begin
        state <= bus.run ? LINK_STALL : LINK_IDLE;
      end
    end
  end

`ifdef ERIS_MARKER_CHECK_EN
  logic mark_bad;
  logic link_err_q;

  always_ff @(posedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      mark_bad   <= 1'b0;
      link_err_q <= 1'b0;
    end else if (at_end) begin
      mark_bad <= 1'b0;
    end else if (at_mark && !bus.is) begin
      mark_bad   <= 1'b1;
      link_err_q <= 1'b1;
    end
  end

  assign word_ok      = !mark_bad;
  assign bus.link_err = link_err_q;
`else
  wire unused_mark = at_mark;
  assign word_ok      = 1'b1;
  assign bus.link_err = 1'b0;
`endif

  assign bus.sync       = sync;
  assign bus.adr_ready  = at_adr_dec && bus.adr_valid;
  assign bus.ia         = in_adr && (state == LINK_SEND) && shift[0];
  assign bus.inst_o     = inst_q;
  assign bus.inst_valid = inst_vld_q;
  assign bus.cur_page   = page_q;

endmodule

// File: tb/tb_ct_rom_link.sv
// Directed bench for ct_rom_link with a behavioural paged ROM on the serial lines.
module tb_ct_rom_link;
  import eris_bus_pkg::*;

  logic cph1 = 1'b0;
  logic pon_n;
  ct_rom_link_if bus();

  ct_rom_link dut (
    .cph1  (cph1),
    .pon_n (pon_n),
    .bus   (bus)
  );

  always #5 cph1 = ~cph1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bench-side bit time, derived from run and pon_n alone.
  int t_ref;
  always @(posedge cph1 or negedge pon_n) begin
    if (!pon_n)           t_ref <= 55;
    else if (t_ref == 55) t_ref <= bus.run ? 0 : 55;
    else                  t_ref <= t_ref + 1;
  end

  // Behavioural ROM: four pages, page switch on opcode 0010000 at bit time 55.
  logic [7:0] rom_adr;
  logic [9:0] rom_word;
  logic [1:0] rom_page;
  logic       mark_off = 1'b0;

  function automatic logic [9:0] rom_data(input logic [1:0] pg, input logic [7:0] a);
    case ({pg, a})
      10'h0A5: return 10'h2B7;
      10'h05A: return 10'h111;
      10'h03C: return 10'h190;  // page select, page 3
      10'h35A: return 10'h3E1;
      default: return {pg, a} ^ 10'h155;
    endcase
  endfunction

  always @(negedge cph1 or negedge pon_n) begin
    if (!pon_n) begin
      rom_adr  <= '0;
      rom_word <= '0;
      rom_page <= '0;
      bus.is   <= 1'b0;
    end else begin
      if (t_ref >= 20 && t_ref <= 27) rom_adr[t_ref-20] <= bus.ia;
      if (t_ref == 28) rom_word <= rom_data(rom_page, rom_adr);
      if (t_ref == 11)                     bus.is <= !mark_off;
      else if (t_ref >= 45 && t_ref <= 54) bus.is <= rom_word[t_ref-45];
      else                                 bus.is <= 1'b0;
      if (t_ref == 55 && rom_word[6:0] == 7'b0010000) rom_page <= rom_word[8:7];
    end
  end

  // Runs one word from bit time 0 to 55, starting at the negedge of the previous bit 55.
  task automatic run_word(input logic vld, input logic [7:0] adr, input logic [9:0] exp_inst,
                          input logic exp_iv, input logic [1:0] exp_page, input logic drop_run,
                          input logic kill_mark, input logic exp_err);
    int rdy_cnt = 0, rdy_t = -1, sync_cnt = 0, sync_t = -1, iv_cnt = 0, iv_t = -1;
    int ia_stray = 0, bad_t = 0;
    logic [7:0] ia_byte = '0;
    logic [9:0] inst_end = '0;
    logic [1:0] page_end = '0;
    bus.adr_valid = vld;
    bus.adr_i     = adr;
    mark_off      = kill_mark;
    for (int k = 0; k < 56; k++) begin
      @(negedge cph1);
      if (t_ref != k) bad_t++;
      if (bus.adr_ready) begin rdy_cnt++; rdy_t = k; end
      if (k >= 20 && k <= 27) ia_byte[k-20] = bus.ia;
      else if (bus.ia) ia_stray++;
      if (!bus.sync) begin sync_cnt++; sync_t = k; end
      if (bus.inst_valid) begin iv_cnt++; iv_t = k; end
      if (k == 55) begin inst_end = bus.inst_o; page_end = bus.cur_page; end
      if (drop_run && k == 30) bus.run = 1'b0;
    end
    mark_off = 1'b0;
    check("bit_align", bad_t, 0);
    check("adr_ready_cnt", rdy_cnt, 32'(vld));
    if (vld) check("adr_ready_t", rdy_t, 19);
    check("ia_field", ia_byte, vld ? adr : 8'h00);
    check("ia_stray", ia_stray, 0);
    check("sync_low_cnt", sync_cnt, 1);
    check("sync_low_t", sync_t, 55);
    check("inst_valid_cnt", iv_cnt, 32'(exp_iv));
    if (exp_iv) check("inst_valid_t", iv_t, 55);
    check("inst_o", inst_end, exp_inst);
    check("cur_page", page_end, exp_page);
    check("link_err", bus.link_err, exp_err);
  endtask

  task automatic wait_t(input int t);
    int n = 0;
    do begin
      @(negedge cph1);
      n++;
    end while (t_ref != t && n < 200);
    if (t_ref != t) check("wait_t", t_ref, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    int v, s, a;
    pon_n         = 1'b0;
    bus.run       = 1'b0;
    bus.adr_valid = 1'b0;
    bus.adr_i     = 8'h00;
    repeat (3) @(negedge cph1);
    check("rst_sync", bus.sync, 1'b1);
    check("rst_ia", bus.ia, 1'b0);
    check("rst_adr_ready", bus.adr_ready, 1'b0);
    check("rst_inst_o", bus.inst_o, 10'h000);
    check("rst_inst_valid", bus.inst_valid, 1'b0);
    check("rst_cur_page", bus.cur_page, 2'd0);
    check("rst_link_err", bus.link_err, 1'b0);

    pon_n   = 1'b1;
    bus.run = 1'b1;
    run_word(1'b1, 8'hA5, 10'h2B7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_word(1'b1, 8'h5A, 10'h111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_word(1'b0, 8'hA5, 10'h111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);  // stall word
    run_word(1'b1, 8'hA5, 10'h2B7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    run_word(1'b1, 8'h3C, 10'h190, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);  // page select
    run_word(1'b1, 8'h5A, 10'h3E1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);  // reads page 3

    // Reset in the middle of a SEND word.
    bus.adr_valid = 1'b1;
    bus.adr_i     = 8'hA5;
    wait_t(50);
    pon_n = 1'b0;
    #1;
    check("mid_rst_sync", bus.sync, 1'b1);
    check("mid_rst_ia", bus.ia, 1'b0);
    check("mid_rst_inst_o", bus.inst_o, 10'h000);
    check("mid_rst_inst_valid", bus.inst_valid, 1'b0);
    check("mid_rst_cur_page", bus.cur_page, 2'd0);
    check("mid_rst_adr_ready", bus.adr_ready, 1'b0);
    v = 0; s = 0;
    repeat (4) begin
      @(negedge cph1);
      v += int'(bus.inst_valid);
      s += int'(!bus.sync);
    end
    check("mid_rst_iv_seen", v, 0);
    check("mid_rst_sync_seen", s, 0);
    pon_n = 1'b1;
    run_word(1'b1, 8'hA5, 10'h2B7, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);

    // run dropped at bit time 30: word completes, then the link idles.
    run_word(1'b1, 8'h5A, 10'h111, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    v = 0; s = 0; a = 0;
    repeat (20) begin
      @(negedge cph1);
      v += int'(bus.inst_valid);
      s += int'(!bus.sync);
      a += int'(bus.ia);
    end
    check("idle_iv_seen", v, 0);
    check("idle_sync_low", s, 0);
    check("idle_ia_seen", a, 0);

    // Missing presence marker.
    bus.run = 1'b1;
`ifdef ERIS_MARKER_CHECK_EN
    run_word(1'b1, 8'hA5, 10'h111, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    run_word(1'b1, 8'h5A, 10'h111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
`else
    run_word(1'b1, 8'hA5, 10'h2B7, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0);
    run_word(1'b1, 8'h5A, 10'h111, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
